calc_n: RTL and testbench
=========================

CALC_N -- requirements
Module: calc_n

Interface
- REQ-001: Parameter NUM_PORTS, default 4, gives the number of independent request/response ports; legal range 1..8.
- REQ-002: Parameter DATA_W, default 32, gives the operand and result width; legal values 8, 16, 32, 64.
- REQ-003: Parameter FIFO_DEPTH, default 2, gives the per-port queue depth in operations; legal values 2, 4, 8, 16.
- REQ-004: c_clk  input  1  single clock; all state updates on its rising edge.
- REQ-005: reset  input  1  asynchronous, active-low reset.
- REQ-006: req_cmd_in  input  4*NUM_PORTS  per-port command; 0=nop, 1=add, 2=sub, 5=shl, 6=shr, all other values invalid.
- REQ-007: req_data_in  input  DATA_W*NUM_PORTS  per-port operand bus.
- REQ-008: req_ready  output  NUM_PORTS  per-port flag: the port's queue can accept a new operation.
- REQ-009: out_resp  output  2*NUM_PORTS  per-port response; 0=none, 1=success, 2=error, 3 is never driven.
- REQ-010: out_data  output  DATA_W*NUM_PORTS  per-port result.

Function
- REQ-011: A request shall take two cycles: cycle A carries a nonzero cmd plus op1, and cycle A+1 carries op2 on data, with cmd ignored in that cycle.
- REQ-012: Invalid commands shall also use the two-cycle protocol.
- REQ-013: Cycle A shall be accepted only if req_ready for that port is 1 in cycle A; otherwise the request is silently dropped.
- REQ-014: Per-port capture FSM states and transitions:
  - IDLE to OP2 on an accepted nonzero cmd.
  - OP2 to IDLE unconditionally, pushing {cmd, op1, op2} into the port queue.
- REQ-015: req_ready shall be 0 while the port FSM is in OP2, and 0 when the queue holds FIFO_DEPTH entries; otherwise it is 1.
- REQ-016: A push and a pop on the same port in the same cycle shall both take effect, and occupancy is unchanged.
- REQ-017: A single shared ALU shall serve at most one operation per cycle, granted round-robin across non-empty queues, starting from the port after the last granted port (port 0 first after reset).
- REQ-018: Results for each port shall be returned in that port's request order.
- REQ-019: Latency: with an uncontended queue, the response shall appear in cycle A+3, i.e. push at end of A+1, grant/pop and compute in A+2, registered output in A+3.
- REQ-020: out_resp and out_data shall be nonzero for exactly one cycle per operation and 0 in all other cycles.
- REQ-021: add: result = op1+op2; a carry out of bit DATA_W-1 gives resp 2 and data 0.
- REQ-022: sub: result = op1-op2; op2>op1 gives resp 2 and data 0; op1==op2 gives resp 1 and data 0.
- REQ-023: shl/shr: op1 shall be shifted logically by the low log2(DATA_W) bits of op2, upper bits ignored, zero fill, resp 1; bits shifted out are lost and are not an error.
- REQ-024: Invalid cmd: resp 2, data 0.
- REQ-025: All arithmetic is unsigned.
- REQ-026: Ports shall be fully independent apart from ALU arbitration; an error on one port has no effect on others.

Reset
- REQ-027: While reset=0, all FSMs shall be IDLE, all queues empty, the round-robin pointer at port 0, and out_resp=0, out_data=0, req_ready=all ones (async assertion, effective immediately).
- REQ-028: Reset asserted mid-operation shall discard all in-flight and queued operations with no response ever issued for them.
- REQ-029: After reset is released, the first request shall be accepted in the first rising edge at which reset=1.

Verification
- REQ-030: Port 0 add 0x1 + 0x1FFFFFFF (DATA_W=32) -> resp 1, data 0x20000000 in cycle A+3, one cycle only.
- REQ-031: Port 1 add 0xFFFFFFFF + 0x1 -> resp 2, data 0. Port 2 sub 0x1 - 0xF -> resp 2, data 0. Port 3 cmd 3 -> resp 2, data 0.
- REQ-032: Shifts:
  - shl 0x1 by op2=0x21 -> data 0x2 (amount 1).
  - shr 0x80000000 by 31 -> data 0x1.
  - shl 0x80000000 by 1 -> resp 1, data 0.
- REQ-033: All 4 ports issue add in the same cycle A -> responses on ports 0,1,2,3 in cycles A+3, A+4, A+5, A+6; a repeat of this with port 2 excluded shall skip port 2.
- REQ-034: Back-to-back requests on port 0 with the ALU saturated by the other ports:
  - req_ready drops after FIFO_DEPTH queued ops.
  - A cmd presented while req_ready=0 yields no response.
  - Remaining results return in order.
- REQ-035: Reset asserted the cycle after a port's cmd cycle -> no response from that port; the next request after release completes normally with latency 3.

Source files
------------

// File: rtl/calc_n.sv
// calc_n: multi-port two-cycle request front end feeding one shared ALU.
// Each port captures {cmd, op1} then op2, queues the operation, and a
// round-robin arbiter hands one queued operation per cycle to the ALU.
// The result is registered and shown on the owning port for one cycle.
//
// Handshake: a port's cmd cycle is accepted on a rising edge only when
// req_ready for that port is 1 during that cycle and cmd is nonzero; the
// following cycle always carries op2 and its cmd lane is ignored. A cmd
// presented while req_ready is 0 is dropped with no response.
module calc_n #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [4*NUM_PORTS-1:0]      req_cmd_in,
  input  logic [DATA_W*NUM_PORTS-1:0] req_data_in,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [2*NUM_PORTS-1:0]      out_resp,
  output logic [DATA_W*NUM_PORTS-1:0] out_data,
  output logic [NUM_PORTS-1:0]        dbg_cap_state
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SH_W   = $clog2(DATA_W);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int ENT_W  = 4 + 2 * DATA_W;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_OP2  = 1'b1
  } cap_state_t;

  // Capture FSM and operand holding registers, one set per port
  cap_state_t         state_q [NUM_PORTS];
  cap_state_t         state_d [NUM_PORTS];
  logic [3:0]         cmd_q   [NUM_PORTS];
  logic [DATA_W-1:0]  op1_q   [NUM_PORTS];

  // Per-port operation queues
  logic [ENT_W-1:0]   fifo_mem [NUM_PORTS][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q [NUM_PORTS];
  logic [PTR_W-1:0]   rd_ptr_q [NUM_PORTS];
  logic [CNT_W-1:0]   count_q  [NUM_PORTS];

  logic [NUM_PORTS-1:0] accept;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;

  // Arbiter
  logic [PORT_W-1:0]  rr_ptr_q;
  logic [PORT_W:0]    cand;
  logic [PORT_W-1:0]  cand_idx;
  logic               grant_valid;
  logic [PORT_W-1:0]  grant_idx;

  // ALU
  logic [ENT_W-1:0]   alu_entry;
  logic [3:0]         alu_cmd;
  logic [DATA_W-1:0]  alu_op1;
  logic [DATA_W-1:0]  alu_op2;
  logic [DATA_W:0]    alu_sum;
  logic [1:0]         alu_resp;
  logic [DATA_W-1:0]  alu_data;

  logic [2*NUM_PORTS-1:0]      resp_d;
  logic [DATA_W*NUM_PORTS-1:0] data_d;

  // Per-port flow control: ready, cmd acceptance, queue push and pop
  always_comb begin
    req_ready     = '0;
    accept        = '0;
    push          = '0;
    pop           = '0;
    dbg_cap_state = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_ready[p]     = (state_q[p] == CAP_IDLE) &&
                         (count_q[p] != CNT_W'(FIFO_DEPTH));
      accept[p]        = req_ready[p] && (req_cmd_in[4*p +: 4] != CMD_NOP);
      push[p]          = (state_q[p] == CAP_OP2);
      pop[p]           = grant_valid && (grant_idx == PORT_W'(p));
      dbg_cap_state[p] = (state_q[p] == CAP_OP2);
    end
  end

  // Capture FSM next state: IDLE -> OP2 on accept, OP2 -> IDLE always
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      state_d[p] = state_q[p];
      case (state_q[p])
        CAP_IDLE: if (accept[p]) state_d[p] = CAP_OP2;
        CAP_OP2:  state_d[p] = CAP_IDLE;
        default:  state_d[p] = CAP_IDLE;
      endcase
    end
  end

  // Capture FSM state register
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= CAP_IDLE;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= state_d[p];
    end
  end

  // Operand capture and queue storage; contents are don't-care until pushed
  always_ff @(posedge c_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (accept[p]) begin
        cmd_q[p] <= req_cmd_in[4*p +: 4];
        op1_q[p] <= req_data_in[DATA_W*p +: DATA_W];
      end
      if (push[p]) begin
        fifo_mem[p][wr_ptr_q[p]] <= {cmd_q[p], op1_q[p],
                                     req_data_in[DATA_W*p +: DATA_W]};
      end
    end
  end

  // Queue pointers and occupancy; simultaneous push and pop cancel out
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        count_q[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (push[p]) wr_ptr_q[p] <= wr_ptr_q[p] + PTR_W'(1);
        if (pop[p])  rd_ptr_q[p] <= rd_ptr_q[p] + PTR_W'(1);
        case ({push[p], pop[p]})
          2'b10:   count_q[p] <= count_q[p] + CNT_W'(1);
          2'b01:   count_q[p] <= count_q[p] - CNT_W'(1);
          default: count_q[p] <= count_q[p];
        endcase
      end
    end
  end

  // Round-robin search for the first non-empty queue at or after rr_ptr_q
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    cand_idx    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr_q} + (PORT_W+1)'(i);
      if (cand >= (PORT_W+1)'(NUM_PORTS)) cand = cand - (PORT_W+1)'(NUM_PORTS);
      cand_idx = cand[PORT_W-1:0];
      if (!grant_valid && (count_q[cand_idx] != '0)) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Priority moves to the port after the one just granted
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
    end else if (grant_valid) begin
      if (grant_idx == PORT_W'(NUM_PORTS - 1)) rr_ptr_q <= '0;
      else                                     rr_ptr_q <= grant_idx + PORT_W'(1);
    end
  end

  // Shared ALU operating on the head of the granted queue
  always_comb begin
    alu_entry = fifo_mem[grant_idx][rd_ptr_q[grant_idx]];
    alu_cmd   = alu_entry[ENT_W-1 -: 4];
    alu_op1   = alu_entry[2*DATA_W-1 -: DATA_W];
    alu_op2   = alu_entry[DATA_W-1:0];
    alu_sum   = {1'b0, alu_op1} + {1'b0, alu_op2};
    alu_resp  = RESP_ERR;
    alu_data  = '0;
    case (alu_cmd)
      CMD_ADD: begin
        if (!alu_sum[DATA_W]) begin
          alu_resp = RESP_OK;
          alu_data = alu_sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (alu_op2 <= alu_op1) begin
          alu_resp = RESP_OK;
          alu_data = alu_op1 - alu_op2;
        end
      end
      CMD_SHL: begin
        alu_resp = RESP_OK;
        alu_data = alu_op1 << alu_op2[SH_W-1:0];
      end
      CMD_SHR: begin
        alu_resp = RESP_OK;
        alu_data = alu_op1 >> alu_op2[SH_W-1:0];
      end
      default: begin
        alu_resp = RESP_ERR;
        alu_data = '0;
      end
    endcase
  end

  // Route the ALU result to the granted port's lanes only
  always_comb begin
    resp_d = '0;
    data_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pop[p]) begin
        resp_d[2*p +: 2]           = alu_resp;
        data_d[DATA_W*p +: DATA_W] = alu_data;
      end
    end
  end

  // Registered response: nonzero for one cycle per operation
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      out_resp <= '0;
      out_data <= '0;
    end else begin
      out_resp <= resp_d;
      out_data <= data_d;
    end
  end

endmodule

// File: tb/tb_calc_n.sv
// Directed bench for calc_n: single-op vector table with exact latency
// checks, multi-port arbitration bursts, reset mid-operation, and a
// saturated back-pressure run scored against an expected queue.
module tb_calc_n;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int FD = 2;

  localparam logic [3:0] ADD = 4'd1;
  localparam logic [3:0] SUB = 4'd2;
  localparam logic [3:0] SHL = 4'd5;
  localparam logic [3:0] SHR = 4'd6;

  logic                 c_clk;
  logic                 reset;
  logic [4*NP-1:0]      req_cmd_in;
  logic [DW*NP-1:0]     req_data_in;
  logic [NP-1:0]        req_ready;
  logic [2*NP-1:0]      out_resp;
  logic [DW*NP-1:0]     out_data;
  logic [NP-1:0]        dbg_cap_state;

  calc_n #(.NUM_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .c_clk         (c_clk),
    .reset         (reset),
    .req_cmd_in    (req_cmd_in),
    .req_data_in   (req_data_in),
    .req_ready     (req_ready),
    .out_resp      (out_resp),
    .out_data      (out_data),
    .dbg_cap_state (dbg_cap_state)
  );

  // Clock and watchdog
  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [16];

  int   n_checks = 0;
  int   n_bad    = 0;
  logic mon_en   = 1'b0;
  int   resp_seen0 = 0;
  // {port[1:0], resp[1:0], data[31:0]}
  logic [35:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] resp_of(input int p);
    return out_resp[2*p +: 2];
  endfunction

  function automatic logic [31:0] data_of(input int p);
    return out_data[DW*p +: DW];
  endfunction

  task automatic drive(input int p, input logic [3:0] cmd, input logic [31:0] data);
    req_cmd_in[4*p +: 4]   = cmd;
    req_data_in[DW*p +: DW] = data;
  endtask

  task automatic drive_zero();
    req_cmd_in  = '0;
    req_data_in = '0;
  endtask

  task automatic check_quiet(input string name);
    for (int p = 0; p < NP; p++) begin
      check($sformatf("%s_resp_p%0d", name, p), 64'(resp_of(p)), 64'd0);
      check($sformatf("%s_data_p%0d", name, p), 64'(data_of(p)), 64'd0);
    end
  endtask

  // Scoreboard: every response must match the oldest expected entry of its port
  task automatic monitor();
    int hits;
    int found;
    hits = 0;
    for (int p = 0; p < NP; p++) begin
      if (resp_of(p) == 2'd0) begin
        check($sformatf("mon_idle_data_p%0d", p), 64'(data_of(p)), 64'd0);
      end else begin
        hits++;
        if (p == 0) resp_seen0++;
        found = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (found < 0 && exp_q[i][35:34] == 2'(p)) found = i;
        if (found < 0) begin
          n_checks++;
          n_bad++;
          $display("FAIL mon_unexpected_p%0d: got resp %0d data %0h expected no response",
                   p, resp_of(p), data_of(p));
        end else begin
          check($sformatf("mon_resp_p%0d", p), 64'(resp_of(p)), 64'(exp_q[found][33:32]));
          check($sformatf("mon_data_p%0d", p), 64'(data_of(p)), 64'(exp_q[found][31:0]));
          exp_q.delete(found);
        end
      end
    end
    check("mon_one_grant", 64'(hits <= 1), 64'd1);
  endtask

  task automatic step();
    @(negedge c_clk);
    if (mon_en) monitor();
  endtask

  // Holds reset for two cycles, checks reset values, releases at a negedge
  task automatic do_reset();
    reset = 1'b0;
    drive_zero();
    #1;
    check("rst_ready", 64'(req_ready), 64'hF);
    check("rst_resp", 64'(out_resp), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_state", 64'(dbg_cap_state), 64'd0);
    step();
    step();
    reset = 1'b1;
  endtask

  // One isolated operation; response must appear exactly in cycle A+3
  task automatic apply_vec(input int idx, input vec_t v);
    check($sformatf("v%0d_ready_a", idx), 64'(req_ready[v.port]), 64'd1);
    drive(v.port, v.cmd, v.op1);
    step();
    check($sformatf("v%0d_ready_op2", idx), 64'(req_ready[v.port]), 64'd0);
    check($sformatf("v%0d_state_op2", idx), 64'(dbg_cap_state[v.port]), 64'd1);
    check($sformatf("v%0d_quiet_a1", idx), 64'(out_resp), 64'd0);
    drive(v.port, 4'hF, v.op2);
    step();
    drive_zero();
    check($sformatf("v%0d_quiet_a2", idx), 64'(out_resp), 64'd0);
    step();
    check($sformatf("v%0d_resp", idx), 64'(resp_of(v.port)), 64'(v.resp));
    check($sformatf("v%0d_data", idx), 64'(data_of(v.port)), 64'(v.data));
    for (int q = 0; q < NP; q++)
      if (q != v.port)
        check($sformatf("v%0d_other_p%0d", idx, q), 64'(resp_of(q)), 64'd0);
    step();
    check($sformatf("v%0d_one_cycle_resp", idx), 64'(out_resp), 64'd0);
    check($sformatf("v%0d_one_cycle_data", idx), 64'(out_data), 64'd0);
  endtask

  // All ports in mask issue add together; round-robin starts at port 0
  task automatic burst(input int id, input logic [3:0] mask);
    int order [$];
    int exp_p;
    logic [1:0]  er;
    logic [31:0] ed;
    order = {};
    for (int p = 0; p < NP; p++)
      if (mask[p]) begin
        drive(p, ADD, 32'h100 * (p + 1));
        order.push_back(p);
      end
    step();
    for (int p = 0; p < NP; p++)
      if (mask[p]) drive(p, 4'd0, 32'(p + 1));
    step();
    drive_zero();
    check($sformatf("b%0d_quiet_a2", id), 64'(out_resp), 64'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      exp_p = (k < order.size()) ? order[k] : -1;
      for (int p = 0; p < NP; p++) begin
        er = (p == exp_p) ? 2'd1 : 2'd0;
        ed = (p == exp_p) ? 32'h100 * (p + 1) + 32'(p + 1) : 32'd0;
        check($sformatf("b%0d_k%0d_resp_p%0d", id, k, p), 64'(resp_of(p)), 64'(er));
        check($sformatf("b%0d_k%0d_data_p%0d", id, k, p), 64'(data_of(p)), 64'(ed));
      end
    end
  endtask

  initial begin
    int          acc0;
    int          seq;
    logic        saw_full;
    logic        dropped;
    logic [31:0] op1v;
    logic [31:0] op2v;
    vec_t        v;

    vecs[0]  = '{0, ADD,   32'h1,        32'h1FFFFFFF, 2'd1, 32'h20000000};
    vecs[1]  = '{1, ADD,   32'hFFFFFFFF, 32'h1,        2'd2, 32'h0};
    vecs[2]  = '{2, SUB,   32'h1,        32'hF,        2'd2, 32'h0};
    vecs[3]  = '{3, 4'd3,  32'h1234,     32'h5678,     2'd2, 32'h0};
    vecs[4]  = '{0, SHL,   32'h1,        32'h21,       2'd1, 32'h2};
    vecs[5]  = '{1, SHR,   32'h80000000, 32'd31,       2'd1, 32'h1};
    vecs[6]  = '{2, SHL,   32'h80000000, 32'h1,        2'd1, 32'h0};
    vecs[7]  = '{3, SUB,   32'h5,        32'h5,        2'd1, 32'h0};
    vecs[8]  = '{0, SUB,   32'h10,       32'h3,        2'd1, 32'hD};
    vecs[9]  = '{1, ADD,   32'h12345678, 32'h11111111, 2'd1, 32'h23456789};
    vecs[10] = '{2, 4'd7,  32'h1,        32'h1,        2'd2, 32'h0};
    vecs[11] = '{3, SHR,   32'hF0,       32'h104,      2'd1, 32'hF};
    vecs[12] = '{0, ADD,   32'hFFFFFFFE, 32'h1,        2'd1, 32'hFFFFFFFF};
    vecs[13] = '{1, 4'd15, 32'hAAAA,     32'h5555,     2'd2, 32'h0};
    vecs[14] = '{2, SHL,   32'hFFFFFFFF, 32'h20,       2'd1, 32'hFFFFFFFF};
    vecs[15] = '{3, ADD,   32'hFFFFFFFF, 32'hFFFFFFFF, 2'd2, 32'h0};

    reset = 1'b0;
    drive_zero();

    // Table vectors; the first is driven on the release edge itself
    do_reset();
    for (int i = 0; i < 16; i++) apply_vec(i, vecs[i]);

    // Arbitration bursts from a freshly reset pointer
    do_reset();
    burst(0, 4'b1111);
    burst(1, 4'b1011);

    // Reset during the op2 cycle discards the operation
    do_reset();
    step();
    drive(1, ADD, 32'h5);
    step();
    reset = 1'b0;
    drive(1, 4'd0, 32'h6);
    #1;
    check("midrst_state", 64'(dbg_cap_state), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'hF);
    check("midrst_resp", 64'(out_resp), 64'd0);
    step();
    step();
    reset = 1'b1;
    drive_zero();
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("midrst_quiet_%0d", i), 64'(out_resp), 64'd0);
    end
    v = '{1, ADD, 32'h7, 32'h8, 2'd1, 32'hF};
    apply_vec(100, v);

    // Saturated ALU: port 0 must fill its queue and drop a cmd while not ready
    do_reset();
    step();
    mon_en     = 1'b1;
    resp_seen0 = 0;
    acc0       = 0;
    seq        = 1;
    saw_full   = 1'b0;
    dropped    = 1'b0;
    for (int c = 0; c < 48; c++) begin
      if (c % 2 == 0) begin
        for (int p = 0; p < NP; p++) begin
          if (p == 0)
            check($sformatf("sat_ready_level_c%0d", c), 64'(req_ready[0]),
                  64'((acc0 - resp_seen0) < FD));
          op1v = 32'h1000 * seq;
          op2v = 32'h5 + (32'(p) << 8);
          if (req_ready[p]) begin
            drive(p, ADD, op1v);
            exp_q.push_back({2'(p), 2'd1, op1v + op2v});
            if (p == 0) acc0++;
            seq++;
          end else if (p == 0 && !dropped) begin
            drive(0, ADD, 32'hDEAD0000);
            dropped  = 1'b1;
            saw_full = 1'b1;
          end else begin
            if (p == 0) saw_full = 1'b1;
            drive(p, 4'd0, 32'd0);
          end
        end
      end else begin
        for (int p = 0; p < NP; p++) drive(p, 4'd0, 32'h5 + (32'(p) << 8));
      end
      step();
    end
    drive_zero();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) step();
    check("sat_drain_empty", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 4; i++) step();
    mon_en = 1'b0;
    check("sat_saw_full", 64'(saw_full), 64'd1);
    check("sat_dropped_issued", 64'(dropped), 64'd1);
    check("sat_port0_count", 64'(resp_seen0), 64'(acc0));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
